// File: rtl/nec_prefetch_queue_pkg.sv
// Shared types for the NEC instruction prefetch queue.
package nec_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    PFQ_IDLE,
    PFQ_FETCH,
    PFQ_DROP
  } nec_pfq_state_t;

  localparam logic [3:0] PFQ_MAX_LEN = 4'd15;

  // Limit a retire count to the bytes actually held.
  function automatic logic [3:0] pfq_clamp(input logic [3:0] req, input logic [3:0] avail);
    return (req > avail) ? avail : req;
  endfunction

endpackage

// File: rtl/nec_prefetch_queue_ring.sv
// Byte ring for the prefetch queue: push 0/1/2 bytes, pop 0..15, clear.
module nec_prefetch_ring #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] push_n,
  input  logic [7:0] push_b0,
  input  logic [7:0] push_b1,
  input  logic [3:0] pop_n,
  output logic [3:0] count,
  output logic [7:0] q0,
  output logic [7:0] q1,
  output logic [7:0] q2
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_nx;
  logic [PTR_W-1:0] head_1;
  logic [PTR_W-1:0] head_2;

  assign tail_nx = tail + PTR_W'(1);
  assign head_1  = head + PTR_W'(1);
  assign head_2  = head + PTR_W'(2);

  // Pointers wrap freely; the separate count keeps full and empty distinct.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 4'd0;
    end else if (clear) begin
      head  <= tail;
      count <= 4'd0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count - pop_n + {2'b00, push_n};
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_n != 2'd0) mem[tail]    <= push_b0;
      if (push_n == 2'd2) mem[tail_nx] <= push_b1;
    end
  end

  assign q0 = (count > 4'd0) ? mem[head]   : 8'h00;
  assign q1 = (count > 4'd1) ? mem[head_1] : 8'h00;
  assign q2 = (count > 4'd2) ? mem[head_2] : 8'h00;

endmodule

// File: rtl/nec_prefetch_queue.sv
// NEC instruction prefetch queue: fetch FSM, fetch IP and retire clamp around a byte ring.
// Optional NEC_PREFETCH_HOLD_EN adds a hold input that blocks new fetch requests.
module nec_prefetch_queue
  import nec_prefetch_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int QUEUE_LIMIT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        flush,
  input  logic [15:0] flush_ip,
  input  logic [3:0]  consume,
  output logic        fetch_req,
  output logic [15:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
`ifdef NEC_PREFETCH_HOLD_EN
  input  logic        hold,
`endif
  output logic [3:0]  q_len,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2
);

  if (QUEUE_LIMIT > int'(PFQ_MAX_LEN) || QUEUE_LIMIT > DEPTH) begin : g_bad_limit
    $error("QUEUE_LIMIT out of range");
  end

  nec_pfq_state_t state;
  logic [15:0]    ip;
  logic           hold_eff;
  logic           clear;
  logic [3:0]     pop_n;
  logic [1:0]     push_n;
  logic [7:0]     push_b0;
  logic [7:0]     push_b1;
  logic           can_issue;

`ifdef NEC_PREFETCH_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  // Issue decision uses the registered length, before this cycle's retire.
  assign can_issue = (int'(q_len) + 2 <= QUEUE_LIMIT);

  always_comb begin
    clear   = ce & flush;
    pop_n   = 4'd0;
    push_n  = 2'd0;
    push_b0 = ip[0] ? fetch_data[15:8] : fetch_data[7:0];
    push_b1 = fetch_data[15:8];
    if (ce && !flush) begin
      pop_n = pfq_clamp(consume, q_len);
      if (fetch_ack && state == PFQ_FETCH) push_n = ip[0] ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PFQ_IDLE;
      fetch_req  <= 1'b0;
      fetch_addr <= 16'h0000;
      ip         <= 16'h0000;
    end else if (ce) begin
      if (flush)              ip <= flush_ip;
      else if (push_n != 2'd0) ip <= ip + {14'd0, push_n};
      case (state)
        PFQ_IDLE: begin
          if (!flush && !hold_eff && can_issue) begin
            state      <= PFQ_FETCH;
            fetch_req  <= 1'b1;
            fetch_addr <= {ip[15:1], 1'b0};
          end
        end
        PFQ_FETCH: begin
          if (fetch_ack) begin
            state     <= PFQ_IDLE;
            fetch_req <= 1'b0;
          end else if (flush) begin
            state <= PFQ_DROP;
          end
        end
        PFQ_DROP: begin
          if (fetch_ack) begin
            state     <= PFQ_IDLE;
            fetch_req <= 1'b0;
          end
        end
        default: begin
          state     <= PFQ_IDLE;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

  nec_prefetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push_n  (push_n),
    .push_b0 (push_b0),
    .push_b1 (push_b1),
    .pop_n   (pop_n),
    .count   (q_len),
    .q0      (q0),
    .q1      (q1),
    .q2      (q2)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && ce && !flush)
      assert (consume <= q_len) else $error("consume %0d exceeds q_len %0d", consume, q_len);
  end
`endif

endmodule

// File: tb/tb_nec_prefetch_queue.sv
// Bench for nec_prefetch_queue: byte-queue reference model plus directed literal checks.
module tb_nec_prefetch_queue;
  localparam int QL = 6;
`ifdef NEC_PREFETCH_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, ce, flush, fetch_ack, hold, fetch_req;
  logic [15:0] flush_ip, fetch_data, fetch_addr;
  logic [3:0]  consume, q_len;
  logic [7:0]  q0, q1, q2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nec_prefetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .flush      (flush),
    .flush_ip   (flush_ip),
    .consume    (consume),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
`ifdef NEC_PREFETCH_HOLD_EN
    .hold       (hold),
`endif
    .q_len      (q_len),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue as a list of bytes plus one outstanding-request record.
  logic [7:0]  mq[$];
  logic [15:0] m_ip, m_addr;
  bit          m_req, m_drop, was_req, h;
  int          len0, n;

  function automatic logic [7:0] mbyte(input int i);
    return (i < mq.size()) ? mq[i] : 8'h00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ip = 16'h0; m_addr = 16'h0; m_req = 0; m_drop = 0;
    end else if (ce) begin
      was_req = m_req;
      len0    = mq.size();
      h       = HOLD_EN && hold;
      if (flush) begin
        mq.delete();
        m_ip = flush_ip;
        if (was_req) begin
          m_drop = !fetch_ack;
          if (fetch_ack) m_req = 0;
        end
      end else begin
        n = (int'(consume) > len0) ? len0 : int'(consume);
        repeat (n) void'(mq.pop_front());
        if (was_req && fetch_ack) begin
          if (!m_drop) begin
            if (m_ip[0]) begin
              mq.push_back(fetch_data[15:8]);
              m_ip = m_ip + 16'd1;
            end else begin
              mq.push_back(fetch_data[7:0]);
              mq.push_back(fetch_data[15:8]);
              m_ip = m_ip + 16'd2;
            end
          end
          m_req = 0; m_drop = 0;
        end
      end
      if (!was_req && !flush && !h && (QL - len0 >= 2)) begin
        m_req  = 1;
        m_addr = {m_ip[15:1], 1'b0};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_q_len", {28'd0, q_len}, mq.size());
      chk("m_q0", {24'd0, q0}, {24'd0, mbyte(0)});
      chk("m_q1", {24'd0, q1}, {24'd0, mbyte(1)});
      chk("m_q2", {24'd0, q2}, {24'd0, mbyte(2)});
      chk("m_fetch_req", {31'd0, fetch_req}, {31'd0, m_req});
      if (m_req) chk("m_fetch_addr", {16'd0, fetch_addr}, {16'd0, m_addr});
    end
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!fetch_req && k < 20) begin
      step();
      k++;
    end
    chk(nm, {31'd0, fetch_req}, 32'd1);
  endtask

  task automatic ack(input logic [15:0] d);
    fetch_data = d;
    fetch_ack  = 1'b1;
    step();
    fetch_ack  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce = 1'b1; flush = 1'b0; flush_ip = 16'h0; consume = 4'd0;
    fetch_ack = 1'b0; fetch_data = 16'h0; hold = 1'b0;
    step(); step();
    chk("rst_q_len", {28'd0, q_len}, 0);
    chk("rst_q0", {24'd0, q0}, 0);
    chk("rst_q1", {24'd0, q1}, 0);
    chk("rst_q2", {24'd0, q2}, 0);
    chk("rst_req", {31'd0, fetch_req}, 0);
    chk("rst_addr", {16'd0, fetch_addr}, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // First fetch after reset.
    step();
    chk("t1_req", {31'd0, fetch_req}, 1);
    chk("t1_addr", {16'd0, fetch_addr}, 16'h0000);
    ack(16'h3412);
    chk("t1_len", {28'd0, q_len}, 2);
    chk("t1_q0", {24'd0, q0}, 8'h12);
    chk("t1_q1", {24'd0, q1}, 8'h34);
    chk("t1_q2", {24'd0, q2}, 8'h00);
    chk("t1_req_fall", {31'd0, fetch_req}, 0);

    // Flush to an odd IP: single-byte fetch.
    flush = 1'b1; flush_ip = 16'h0101; step(); flush = 1'b0;
    chk("t2_len", {28'd0, q_len}, 0);
    wait_req("t2_req");
    chk("t2_addr", {16'd0, fetch_addr}, 16'h0100);
    ack(16'hBBAA);
    chk("t2_len1", {28'd0, q_len}, 1);
    chk("t2_q0", {24'd0, q0}, 8'hBB);
    chk("t2_q1", {24'd0, q1}, 8'h00);
    step();
    chk("t2_next_addr", {16'd0, fetch_addr}, 16'h0102);
    ack(16'h4433);
    chk("t2_len3", {28'd0, q_len}, 3);

    // Fill to the limit.
    flush = 1'b1; flush_ip = 16'h0200; step(); flush = 1'b0;
    chk("t3_len0", {28'd0, q_len}, 0);
    wait_req("t3_req_a"); chk("t3_addr_a", {16'd0, fetch_addr}, 16'h0200); ack(16'h2211);
    wait_req("t3_req_b"); chk("t3_addr_b", {16'd0, fetch_addr}, 16'h0202); ack(16'h4433);
    wait_req("t3_req_c"); chk("t3_addr_c", {16'd0, fetch_addr}, 16'h0204); ack(16'h6655);
    chk("t3_len6", {28'd0, q_len}, 6);
    chk("t3_q0", {24'd0, q0}, 8'h11);
    chk("t3_q2", {24'd0, q2}, 8'h33);
    step(); step(); step();
    chk("t3_full_noreq", {31'd0, fetch_req}, 0);
    chk("t3_full_len", {28'd0, q_len}, 6);
    consume = 4'd2; step(); consume = 4'd0;
    chk("t3_len4", {28'd0, q_len}, 4);
    chk("t3_q0b", {24'd0, q0}, 8'h33);
    chk("t3_q2b", {24'd0, q2}, 8'h55);
    chk("t3_req_lag", {31'd0, fetch_req}, 0);
    step();
    chk("t3_req_again", {31'd0, fetch_req}, 1);
    chk("t3_addr_d", {16'd0, fetch_addr}, 16'h0206);

    // Consume and push in the same cycle.
    consume = 4'd3; ack(16'h8877); consume = 4'd0;
    chk("t5_len", {28'd0, q_len}, 3);
    chk("t5_q0", {24'd0, q0}, 8'h66);
    chk("t5_q1", {24'd0, q1}, 8'h77);
    chk("t5_q2", {24'd0, q2}, 8'h88);

    // Flush with a request outstanding: data dropped, request held until ack.
    step();
    chk("t4_addr", {16'd0, fetch_addr}, 16'h0208);
    flush = 1'b1; flush_ip = 16'h2000; step(); flush = 1'b0;
    chk("t4_len0", {28'd0, q_len}, 0);
    chk("t4_req_held", {31'd0, fetch_req}, 1);
    step(); step();
    ack(16'hFFFF);
    chk("t4_dropped", {28'd0, q_len}, 0);
    chk("t4_req_fall", {31'd0, fetch_req}, 0);
    step();
    chk("t4_req", {31'd0, fetch_req}, 1);
    chk("t4_addr2", {16'd0, fetch_addr}, 16'h2000);
    ack(16'h1234);
    chk("t4_q0", {24'd0, q0}, 8'h34);
    chk("t4_q1", {24'd0, q1}, 8'h12);

    // Address wrap at the top of the segment.
    flush = 1'b1; flush_ip = 16'hFFFE; step(); flush = 1'b0;
    step();
    chk("wrap_addr", {16'd0, fetch_addr}, 16'hFFFE);
    ack(16'hCDAB);
    chk("wrap_q0", {24'd0, q0}, 8'hAB);
    chk("wrap_q1", {24'd0, q1}, 8'hCD);
    step();
    chk("wrap_next", {16'd0, fetch_addr}, 16'h0000);

    // Clock enable low: ack ignored, state frozen.
    ce = 1'b0; fetch_data = 16'h5566; fetch_ack = 1'b1;
    step(); step();
    chk("ce_len", {28'd0, q_len}, 2);
    chk("ce_req", {31'd0, fetch_req}, 1);
    ce = 1'b1; step(); fetch_ack = 1'b0;
    chk("ce_len4", {28'd0, q_len}, 4);
    chk("ce_q2", {24'd0, q2}, 8'h66);

    if (HOLD_EN) begin
      flush = 1'b1; flush_ip = 16'h0000; hold = 1'b1; step(); flush = 1'b0;
      step(); step();
      chk("hold_noreq", {31'd0, fetch_req}, 0);
      hold = 1'b0; step();
      chk("hold_release", {31'd0, fetch_req}, 1);
    end

    wait_req("final_req");
    ack(16'h0F0E);
    step(); step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
